uart_tx_drain: RTL and testbench

Serial transmitter that drains bytes from the upstream `fifo_buffer` and shifts them out as 8N1/8N2 UART frames. It sits directly downstream of the FIFO's read port. It treats `data_out` as first-word-fall-through: data is valid whenever `nonempty` is high, and the byte is popped with a one-cycle `next` pulse. This is the block that carries outbound bytes from the FPGA to the host link.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 43 ++++
 rtl/uart_tx_drain.sv | 142 ++++++++++++++
 tb/tb_uart_tx_drain.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
//   uart_tx_state_t           : transmitter FSM states
//   UART_DEFAULT_CLKS_PER_BIT : 50 MHz system clock at 115200 baud
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_tx_state_t;

    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Counts 0 .. ClksPerBit-1 and wraps; restart_i holds/forces the count to 0.
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   restart_i  : zero the count (start of a new bit period next cycle)
//   bit_done_o : high on the last cycle of each bit period
module uart_bit_timer #(
    parameter int unsigned ClksPerBit = 434
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart_i,
    output logic bit_done_o
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

    if (ClksPerBit < 2) begin : g_bad_cpb
        $error("uart_bit_timer: ClksPerBit must be at least 2");
    end

    logic [CntW-1:0] cnt_q, cnt_d;

    // Not gated by restart_i: the top level derives restart from bit_done.
    assign bit_done_o = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart_i || bit_done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a first-word-fall-through FIFO and sends
// 8N1/8N2 frames, back to back when data is waiting.
//   clk_i           : system clock
//   reset_i         : synchronous active-high reset
//   enable_i        : permits new frames; a frame in flight always completes
//   fifo_data_i     : FIFO head byte, valid while fifo_nonempty_i is high
//   fifo_nonempty_i : FIFO holds at least one byte
//   fifo_next_o     : pop strobe, one cycle per byte, same cycle as the latch
//   tx_o            : serial line, idle high (registered)
//   busy_o          : frame in progress (registered)
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned ClksPerBit = UART_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned StopBits   = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [DataWidth-1:0] fifo_data_i,
    input  logic                 fifo_nonempty_i,
    output logic                 fifo_next_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int unsigned IdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DataWidth - 1);

    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $error("uart_tx_drain: StopBits must be 1 or 2");
    end

    uart_tx_state_t       state_q, state_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic bit_done;
    logic last_stop;
    logic frame_end;
    logic latch;
    logic restart;

    uart_bit_timer #(
        .ClksPerBit(ClksPerBit)
    ) u_bit_timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .restart_i (restart),
        .bit_done_o(bit_done)
    );

    assign last_stop = (StopBits == 1) ? 1'b1 : stop_q;
    assign frame_end = (state_q == StStop) && bit_done && last_stop;
    // Gated by reset so a pending byte is never popped while held in reset.
    assign latch     = !reset_i && enable_i && fifo_nonempty_i &&
                       ((state_q == StIdle) || frame_end);
    // Timer sits at zero while idle so the start bit gets a full period.
    assign restart   = (state_q == StIdle) || latch;

    assign fifo_next_o = latch;
    assign tx_o        = tx_q;
    assign busy_o      = busy_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        unique case (state_q)
            StIdle: begin
                if (latch) begin
                    shift_d = fifo_data_i;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxLast) begin
                        stop_d  = 1'b0;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (last_stop) begin
                        if (latch) begin
                            shift_d = fifo_data_i;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next state so tx changes with the state.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: two instances (one and two stop bits) fed from
// separate FIFO queues carrying the same bytes, checked every cycle against a
// frame-level model, plus table-driven scenario totals and hand-checked corners.
module tb_uart_tx_drain;

    localparam int unsigned Cpb = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] fdata [2];
    logic [1:0] fne;
    logic [1:0] fnext;
    logic [1:0] tx;
    logic [1:0] busy;

    always #5 clk = ~clk;

    uart_tx_drain #(
        .DataWidth (8),
        .ClksPerBit(Cpb),
        .StopBits  (1)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .enable_i       (enable),
        .fifo_data_i    (fdata[0]),
        .fifo_nonempty_i(fne[0]),
        .fifo_next_o    (fnext[0]),
        .tx_o           (tx[0]),
        .busy_o         (busy[0])
    );

    uart_tx_drain #(
        .DataWidth (8),
        .ClksPerBit(Cpb),
        .StopBits  (2)
    ) dut2 (
        .clk_i          (clk),
        .reset_i        (reset),
        .enable_i       (enable),
        .fifo_data_i    (fdata[1]),
        .fifo_nonempty_i(fne[1]),
        .fifo_next_o    (fnext[1]),
        .tx_o           (tx[1]),
        .busy_o         (busy[1])
    );

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         en_drop;  // cycle enable falls, -1 = never
        int         rst_at;   // cycle of one-cycle reset pulse, -1 = never
        int         exp_pops;
        int         exp_busy;
        int         exp_gap;  // spacing of first two pops, 0 = not checked
    } vec_t;

    vec_t vecs [4];

    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         m_active [2];
    int         m_k [2];
    logic [7:0] m_byte [2];
    int         cyc;
    int         pop_cnt0;
    int         busy_cnt0;
    int         pop_cyc0 [$];
    int         pop_cyc1 [$];
    logic       tx1_hist [256];

    function automatic int flen(int d);
        return (d == 0) ? (1 + 8 + 1) * Cpb : (1 + 8 + 2) * Cpb;
    endfunction

    // Line level at cycle k of a frame: start bit, 8 data bits LSB first, stop.
    function automatic logic fbit(logic [7:0] b, int k);
        int i;
        i = k / Cpb;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    task automatic check1(string name, int d, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %b want %b", name, d, cyc, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic refresh();
        fne[0]   = (q0.size() != 0);
        fne[1]   = (q1.size() != 0);
        fdata[0] = (q0.size() != 0) ? q0[0] : 8'h00;
        fdata[1] = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic push(logic [7:0] b);
        q0.push_back(b);
        q1.push_back(b);
        refresh();
    endtask

    task automatic tick();
        logic [1:0] popped;
        logic       exp_tx;
        logic       exp_pop;
        logic [7:0] head;
        bit         ne;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            ne      = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
            head    = (d == 0) ? fdata[0] : fdata[1];
            exp_tx  = m_active[d] ? fbit(m_byte[d], m_k[d]) : 1'b1;
            exp_pop = !reset && enable && ne && (!m_active[d] || m_k[d] == flen(d) - 1);
            if (chk_en) begin
                check1("tx", d, tx[d], exp_tx);
                check1("busy", d, busy[d], m_active[d]);
                check1("fifo_next", d, fnext[d], exp_pop);
            end
            popped[d] = fnext[d];
            if (reset) begin
                m_active[d] = 1'b0;
            end else if (exp_pop) begin
                m_active[d] = 1'b1;
                m_k[d]      = 0;
                m_byte[d]   = head;
            end else if (m_active[d] && m_k[d] == flen(d) - 1) begin
                m_active[d] = 1'b0;
            end else if (m_active[d]) begin
                m_k[d]++;
            end
        end
        if (busy[0] === 1'b1) busy_cnt0++;
        if (fnext[0] === 1'b1) begin
            pop_cnt0++;
            pop_cyc0.push_back(cyc);
        end
        if (fnext[1] === 1'b1) pop_cyc1.push_back(cyc);
        if (cyc < 256) tx1_hist[cyc] = tx[1];
        cyc++;
        @(posedge clk);
        #1;
        if (popped[0] === 1'b1 && q0.size() != 0) void'(q0.pop_front());
        if (popped[1] === 1'b1 && q1.size() != 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic restart_dut();
        reset  = 1'b1;
        enable = 1'b1;
        q0.delete();
        q1.delete();
        refresh();
        repeat (2) tick();
        reset     = 1'b0;
        cyc       = 0;
        pop_cnt0  = 0;
        busy_cnt0 = 0;
        pop_cyc0.delete();
        pop_cyc1.delete();
    endtask

    initial begin
        vecs[0] = '{1, 8'hA5, 8'h00, -1, -1, 1, 40, 0};   // single byte
        vecs[1] = '{2, 8'h00, 8'hFF, -1, -1, 2, 80, 40};  // back to back
        vecs[2] = '{2, 8'h11, 8'h22, 10, -1, 1, 40, 0};   // enable drop
        vecs[3] = '{2, 8'h3C, 8'h5A, -1, 15, 2, 55, 16};  // reset mid-frame

        for (int d = 0; d < 2; d++) begin
            m_active[d] = 1'b0;
            m_k[d]      = 0;
            m_byte[d]   = 8'h00;
        end
        cyc = 0;

        // Reset held three cycles with data waiting: nothing may move.
        reset  = 1'b1;
        enable = 1'b1;
        push(8'h77);
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check_int("reset_no_pop", pop_cnt0, 0);

        for (int v = 0; v < 4; v++) begin
            restart_dut();
            push(vecs[v].b0);
            if (vecs[v].nbytes > 1) push(vecs[v].b1);
            for (int c = 0; c < 100; c++) begin
                enable = !(vecs[v].en_drop >= 0 && c >= vecs[v].en_drop);
                reset  = (c == vecs[v].rst_at);
                tick();
            end
            reset = 1'b0;
            check_int($sformatf("v%0d_pops", v), pop_cnt0, vecs[v].exp_pops);
            check_int($sformatf("v%0d_busy", v), busy_cnt0, vecs[v].exp_busy);
            check_int($sformatf("v%0d_first_pop", v),
                      (pop_cyc0.size() != 0) ? pop_cyc0[0] : -1, 0);
            if (vecs[v].exp_gap != 0) begin
                check_int($sformatf("v%0d_gap", v),
                          (pop_cyc0.size() >= 2) ? pop_cyc0[1] - pop_cyc0[0] : -1,
                          vecs[v].exp_gap);
            end
        end

        // Two stop bits: 0x81 then 0x42; frame is 44 cycles.
        restart_dut();
        push(8'h81);
        push(8'h42);
        for (int c = 0; c < 100; c++) tick();
        check_int("stop2_second_pop", (pop_cyc1.size() >= 2) ? pop_cyc1[1] : -1, 44);
        check_int("stop1_second_pop", (pop_cyc0.size() >= 2) ? pop_cyc0[1] : -1, 40);
        check1("stop2_start", 1, tx1_hist[1], 1'b0);
        check1("stop2_bit6", 1, tx1_hist[32], 1'b0);
        for (int c = 37; c <= 44; c++) check1("stop2_tail", 1, tx1_hist[c], 1'b1);

        // Random traffic, enable toggling and occasional reset.
        restart_dut();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 4) push(8'($urandom));
            enable = ($urandom_range(0, 15) != 0);
            reset  = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
